// File: rtl/led_counter_pkg.sv
// Shared definitions for the LED counter generator: mode encodings and prescaler sizing.
package led_counter_pkg;

   localparam logic [1:0] MODE_UP      = 2'b00;
   localparam logic [1:0] MODE_DOWN    = 2'b01;
   localparam logic [1:0] MODE_BOUNCE  = 2'b10;
   localparam logic [1:0] MODE_ONESHOT = 2'b11;

   // Prescaler register width; a PRESCALE of 1 still needs a 1-bit register.
   function automatic int prescale_width(input int n);
      int w_s;
      w_s = $clog2(n);
      if (w_s < 32'sd1) begin
         return 32'sd1;
      end else begin
         return w_s;
      end
   endfunction

endpackage

// File: rtl/led_cnt_prescaler.sv
// Divides clk into count steps: step is high on the last enabled cycle of each PRESCALE window.
module led_cnt_prescaler
   import led_counter_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic enable,
   output logic step
);

   localparam int             PW     = prescale_width(PRESCALE);
   localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
   localparam logic [PW-1:0] P_ONE  = PW'(1);

   logic [PW-1:0] p_r;

   assign step = enable && (p_r == P_LAST);

   // Phase counter: wraps on step, frozen while enable is low.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         p_r <= '0;
      end else if (step) begin
         p_r <= '0;
      end else if (enable) begin
         p_r <= p_r + P_ONE;
      end else begin
         p_r <= p_r;
      end
   end

endmodule

// File: rtl/led_counter_gen.sv
// Multi-mode LED counter (up/down/bounce/one-shot) with load, prescaler and status pulses.
// Define LED_COUNTER_GEN_GRAY_OUT_EN to drive the LEDs with the Gray-coded count.
module led_counter_gen #(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] cnt,
   output logic [WIDTH-1:0] led,
   output logic             tick,
   output logic             tc,
   output logic             done
);

   import led_counter_pkg::*;

   localparam logic [WIDTH-1:0] CNT_MAX    = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CNT_ZERO   = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);
   localparam logic [WIDTH-1:0] CNT_MAX_M1 = CNT_MAX - CNT_ONE;

   logic             step_s;
   logic [WIDTH-1:0] cnt_r;
   logic [WIDTH-1:0] led_r;
   logic             tick_r;
   logic             tc_r;
   logic             done_r;
   logic             dir_up_r;

   logic [WIDTH-1:0] cnt_nxt_s;
   logic [WIDTH-1:0] led_nxt_s;
   logic             tick_nxt_s;
   logic             tc_nxt_s;
   logic             done_nxt_s;
   logic             dir_up_nxt_s;

   led_cnt_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (enable),
      .step    (step_s)
   );

   // Next-state logic; load wins over a coincident step, which is then discarded.
   always_comb begin
      cnt_nxt_s    = cnt_r;
      dir_up_nxt_s = dir_up_r;
      done_nxt_s   = done_r;
      tick_nxt_s   = 1'b0;
      tc_nxt_s     = 1'b0;
      if (load) begin
         cnt_nxt_s    = load_val;
         dir_up_nxt_s = 1'b1;
         done_nxt_s   = 1'b0;
      end else if (step_s) begin
         tick_nxt_s = 1'b1;
         case (mode)
            MODE_UP: begin
               cnt_nxt_s = cnt_r + CNT_ONE;
               tc_nxt_s  = (cnt_r == CNT_MAX);
            end
            MODE_DOWN: begin
               cnt_nxt_s = cnt_r - CNT_ONE;
               tc_nxt_s  = (cnt_r == CNT_ZERO);
            end
            MODE_BOUNCE: begin
               if (dir_up_r) begin
                  if (cnt_r == CNT_MAX) begin
                     cnt_nxt_s    = CNT_MAX_M1;
                     dir_up_nxt_s = 1'b0;
                     tc_nxt_s     = 1'b1;
                  end else begin
                     cnt_nxt_s = cnt_r + CNT_ONE;
                  end
               end else begin
                  if (cnt_r == CNT_ZERO) begin
                     cnt_nxt_s    = CNT_ONE;
                     dir_up_nxt_s = 1'b1;
                     tc_nxt_s     = 1'b1;
                  end else begin
                     cnt_nxt_s = cnt_r - CNT_ONE;
                  end
               end
            end
            MODE_ONESHOT: begin
               // A count loaded straight at MAX finishes on its first step without wrapping.
               if (done_r) begin
                  cnt_nxt_s = cnt_r;
               end else if (cnt_r == CNT_MAX) begin
                  done_nxt_s = 1'b1;
                  tc_nxt_s   = 1'b1;
               end else begin
                  cnt_nxt_s = cnt_r + CNT_ONE;
                  if (cnt_r == CNT_MAX_M1) begin
                     done_nxt_s = 1'b1;
                     tc_nxt_s   = 1'b1;
                  end else begin
                     done_nxt_s = done_r;
                  end
               end
            end
            default: begin
               cnt_nxt_s = cnt_r;
            end
         endcase
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

`ifdef LED_COUNTER_GEN_GRAY_OUT_EN
   assign led_nxt_s = cnt_nxt_s ^ {1'b0, cnt_nxt_s[WIDTH-1:1]};
`else
   assign led_nxt_s = cnt_nxt_s;
`endif

   // State and output registers; direction is held up outside bounce mode.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_r    <= CNT_ZERO;
         led_r    <= CNT_ZERO;
         tick_r   <= 1'b0;
         tc_r     <= 1'b0;
         done_r   <= 1'b0;
         dir_up_r <= 1'b1;
      end else begin
         cnt_r    <= cnt_nxt_s;
         led_r    <= led_nxt_s;
         tick_r   <= tick_nxt_s;
         tc_r     <= tc_nxt_s;
         done_r   <= done_nxt_s;
         dir_up_r <= dir_up_nxt_s | (mode != MODE_BOUNCE);
      end
   end

   assign cnt  = cnt_r;
   assign led  = led_r;
   assign tick = tick_r;
   assign tc   = tc_r;
   assign done = done_r;

endmodule

// File: tb/tb_led_counter_gen.sv
// Directed self-checking bench for led_counter_gen: one PRESCALE=1 and one PRESCALE=4 instance.
module tb_led_counter_gen;

   import led_counter_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n_s;
   logic       enable_s;
   logic [1:0] mode_s;
   logic       load_s;
   logic [3:0] load_val_s;

   logic [3:0] cnt1_s, led1_s, cnt4_s, led4_s;
   logic       tick1_s, tc1_s, done1_s, tick4_s, tc4_s, done4_s;

   int errors_cnt = 0;
   int checks_cnt = 0;

   always #5 clk = ~clk;

   led_counter_gen #(.WIDTH(4), .PRESCALE(1)) dut1 (
      .clk (clk), .reset_n (reset_n_s), .enable (enable_s), .mode (mode_s),
      .load (load_s), .load_val (load_val_s), .cnt (cnt1_s), .led (led1_s),
      .tick (tick1_s), .tc (tc1_s), .done (done1_s)
   );

   led_counter_gen #(.WIDTH(4), .PRESCALE(4)) dut4 (
      .clk (clk), .reset_n (reset_n_s), .enable (enable_s), .mode (mode_s),
      .load (load_s), .load_val (load_val_s), .cnt (cnt4_s), .led (led4_s),
      .tick (tick4_s), .tc (tc4_s), .done (done4_s)
   );

   function automatic int led_exp(input int c);
      logic [3:0] v;
      v = 4'(c);
`ifdef LED_COUNTER_GEN_GRAY_OUT_EN
      return int'(v ^ {1'b0, v[3:1]});
`else
      return int'(v);
`endif
   endfunction

   task automatic check_val(input string tag, input int obs, input int exp);
      checks_cnt++;
      if (obs != exp) begin
         errors_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clk_tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input int c, input int tk, input int t, input int d);
      check_val({tag, ".cnt"},  int'(cnt1_s),  c);
      check_val({tag, ".led"},  int'(led1_s),  led_exp(c));
      check_val({tag, ".tick"}, int'(tick1_s), tk);
      check_val({tag, ".tc"},   int'(tc1_s),   t);
      check_val({tag, ".done"}, int'(done1_s), d);
   endtask

   task automatic chk4(input string tag, input int c, input int tk, input int t, input int d);
      check_val({tag, ".cnt4"},  int'(cnt4_s),  c);
      check_val({tag, ".led4"},  int'(led4_s),  led_exp(c));
      check_val({tag, ".tick4"}, int'(tick4_s), tk);
      check_val({tag, ".tc4"},   int'(tc4_s),   t);
      check_val({tag, ".done4"}, int'(done4_s), d);
   endtask

   task automatic do_load(input int v);
      load_s     = 1'b1;
      load_val_s = 4'(v);
      clk_tick();
      load_s     = 1'b0;
   endtask

   initial begin
      int k;
      int e;
      int bseq[5];
      reset_n_s  = 1'b0;
      enable_s   = 1'b0;
      mode_s     = MODE_UP;
      load_s     = 1'b0;
      load_val_s = 4'd0;
      clk_tick();
      chk1("reset", 0, 0, 0, 0);
      chk4("reset", 0, 0, 0, 0);

      // Up count with wrap
      reset_n_s = 1'b1;
      enable_s  = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         clk_tick();
         chk1("up", i % 16, 1, (i == 16) ? 1 : 0, 0);
      end

      // Prescaler with an enable gap
      reset_n_s = 1'b0;
      clk_tick();
      reset_n_s = 1'b1;
      k = 0;
      for (int c = 0; c < 14; c++) begin
         enable_s = (c >= 6 && c < 9) ? 1'b0 : 1'b1;
         clk_tick();
         if (enable_s) k++;
         check_val("presc.cnt4", int'(cnt4_s), k / 4);
         check_val("presc.tick4", int'(tick4_s),
                   (enable_s && k > 0 && (k % 4) == 0) ? 1 : 0);
      end

      // Bounce
      enable_s = 1'b1;
      mode_s   = MODE_BOUNCE;
      do_load(0);
      chk1("bnc.load", 0, 0, 0, 0);
      for (int i = 1; i <= 31; i++) begin
         clk_tick();
         e = (i <= 15) ? i : ((i <= 30) ? 30 - i : 1);
         chk1("bnc", e, 1, (i == 16 || i == 31) ? 1 : 0, 0);
      end
      do_load(12);
      chk1("bnc.load12", 12, 0, 0, 0);
      bseq = '{13, 14, 15, 14, 13};
      for (int i = 0; i < 5; i++) begin
         clk_tick();
         chk1("bnc2", bseq[i], 1, (i == 3) ? 1 : 0, 0);
      end
      do_load(7);
      chk1("bnc.load7", 7, 0, 0, 0);
      clk_tick();
      chk1("bnc.dir_up", 8, 1, 0, 0);

      // One-shot
      mode_s = MODE_ONESHOT;
      do_load(13);
      chk1("os.load", 13, 0, 0, 0);
      clk_tick();
      chk1("os.14", 14, 1, 0, 0);
      clk_tick();
      chk1("os.15", 15, 1, 1, 1);
      clk_tick();
      chk1("os.hold1", 15, 1, 0, 1);
      clk_tick();
      chk1("os.hold2", 15, 1, 0, 1);
      do_load(0);
      chk1("os.clear", 0, 0, 0, 0);

      // Load coincident with a prescaled step
      mode_s    = MODE_UP;
      reset_n_s = 1'b0;
      clk_tick();
      reset_n_s = 1'b1;
      do_load(15);
      chk4("ld.15", 15, 0, 0, 0);
      clk_tick();
      clk_tick();
      chk4("ld.wait", 15, 0, 0, 0);
      do_load(5);
      chk4("ld.coinc", 5, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         clk_tick();
         chk4("ld.hold", 5, 0, 0, 0);
      end
      clk_tick();
      chk4("ld.next", 6, 1, 0, 0);

      // Reset mid-count overrides load/enable
      reset_n_s  = 1'b0;
      load_s     = 1'b1;
      load_val_s = 4'd9;
      clk_tick();
      chk1("rst.mid", 0, 0, 0, 0);
      chk4("rst.mid", 0, 0, 0, 0);
      reset_n_s = 1'b1;
      enable_s  = 1'b0;
      do_load(6);
      chk1("led6", 6, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
      $finish;
   end

endmodule
